// File: rtl/exu_mul_arb_if.sv
// Requester, multiplier-packet and result signals of the shared multiplier arbiter.
// slave = arbiter side, master = requesters/multiplier side.
interface exu_mul_arb_if #(
    parameter int unsigned TAG_W = 5
);
    logic             req0_valid;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic             req0_rs1_sign;
    logic             req0_rs2_sign;
    logic             req0_low;
    logic [TAG_W-1:0] req0_tag;
    logic             req0_ready;

    logic             req1_valid;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic             req1_rs1_sign;
    logic             req1_rs2_sign;
    logic             req1_low;
    logic [TAG_W-1:0] req1_tag;
    logic             req1_ready;

    logic             mul_valid;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_rs1_sign;
    logic             mul_rs2_sign;
    logic             mul_low;
    logic [31:0]      mul_result;

    logic             res_valid;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;
    logic [31:0]      res_data;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_tag,
        input  mul_result,
        output req0_ready, req1_ready,
        output mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low,
        output res_valid, res_id, res_tag, res_data, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_tag,
        output req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_tag,
        output mul_result,
        input  req0_ready, req1_ready,
        input  mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low,
        input  res_valid, res_id, res_tag, res_data, busy
    );
endinterface

// File: rtl/exu_mul_arb.sv
// Two-requester arbiter/sequencer for the shared LAT-stage pipelined multiplier.
// Define RV_MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module exu_mul_arb #(
    parameter int unsigned LAT   = 3,
    parameter int unsigned TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         freeze,
    input  logic         flush,
    exu_mul_arb_if.slave bus
);
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic             vld;
        logic             id;
        logic [TAG_W-1:0] tag;
    } trk_t;

    trk_t [LAT-1:0]   trk_q, trk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_en;
    logic             win1;
    logic             sel1;
    logic             retire;
    logic [TAG_W-1:0] win_tag;

`ifdef RV_MUL_ARB_RR_EN
    logic last_q, last_d;
`endif

    // Winner selection; grants are suppressed while reset is asserted.
    always_comb begin : arb
        grant_en = rst_l & ~freeze & ~flush & (bus.req0_valid | bus.req1_valid);
`ifdef RV_MUL_ARB_RR_EN
        win1     = bus.req1_valid & (~bus.req0_valid | ~last_q);
        last_d   = grant_en ? win1 : last_q;
`else
        win1     = bus.req1_valid & ~bus.req0_valid;
`endif
        sel1     = grant_en & win1;
        win_tag  = sel1 ? bus.req1_tag : bus.req0_tag;
    end

    // Operand packet follows the winner, req0 when idle.
    always_comb begin : pkt
        bus.req0_ready   = grant_en & ~win1;
        bus.req1_ready   = sel1;
        bus.mul_valid    = grant_en;
        bus.mul_a        = bus.req0_a;
        bus.mul_b        = bus.req0_b;
        bus.mul_rs1_sign = bus.req0_rs1_sign;
        bus.mul_rs2_sign = bus.req0_rs2_sign;
        bus.mul_low      = bus.req0_low;
        if (sel1) begin
            bus.mul_a        = bus.req1_a;
            bus.mul_b        = bus.req1_b;
            bus.mul_rs1_sign = bus.req1_rs1_sign;
            bus.mul_rs2_sign = bus.req1_rs2_sign;
            bus.mul_low      = bus.req1_low;
        end
    end

    // Id/tag tracker mirrors the multiplier pipe; flush kills, freeze holds.
    always_comb begin : track
        trk_d = trk_q;
        if (flush) begin
            for (int unsigned i = 0; i < LAT; i++) trk_d[i].vld = 1'b0;
        end else if (!freeze) begin
            trk_d[0] = '{vld: grant_en, id: win1, tag: win_tag};
            for (int unsigned i = 1; i < LAT; i++) trk_d[i] = trk_q[i-1];
        end
    end

    assign retire = trk_q[LAT-1].vld & ~freeze & ~flush;

    always_comb begin : count
        cnt_d = cnt_q;
        if (flush) cnt_d = '0;
        else       cnt_d = cnt_q + CNT_W'(grant_en) - CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_l) begin : regs
        if (!rst_l) begin
            trk_q  <= '0;
            cnt_q  <= '0;
`ifdef RV_MUL_ARB_RR_EN
            last_q <= 1'b0;
`endif
        end else begin
            trk_q  <= trk_d;
            cnt_q  <= cnt_d;
`ifdef RV_MUL_ARB_RR_EN
            last_q <= last_d;
`endif
        end
    end

    assign bus.res_valid = retire;
    assign bus.res_id    = trk_q[LAT-1].id;
    assign bus.res_tag   = trk_q[LAT-1].tag;
    assign bus.res_data  = bus.mul_result;
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_exu_mul_arb.sv
// Randomised self-checking bench for exu_mul_arb against an in-flight-list reference model.
// Honours RV_MUL_ARB_RR_EN the same way as the design.
module tb_exu_mul_arb;
    localparam int unsigned LAT   = 3;
    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst_l, freeze, flush;

    exu_mul_arb_if #(.TAG_W(TAG_W)) bus ();

    exu_mul_arb #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Each in-flight multiply: owner, tag, true product, unfrozen edges since issue.
    typedef struct {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      prod;
        int               age;
    } ent_t;
    ent_t inflight[$];
`ifdef RV_MUL_ARB_RR_EN
    logic last_win = 1'b0;
`endif

    logic             exp_g0, exp_g1, exp_rv, exp_id, exp_busy;
    logic [TAG_W-1:0] exp_tag;
    logic [31:0]      exp_data, exp_ma, exp_mb;
    logic             exp_s1, exp_s2, exp_low;

    function automatic logic [31:0] mul_ref(input logic [31:0] a, b, input logic sa, sb, low);
        logic signed [65:0] ea, eb, p;
        ea = sa ? {{34{a[31]}}, a} : {34'd0, a};
        eb = sb ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return low ? p[31:0] : p[63:32];
    endfunction

    task automatic set_req(input int n, input logic [31:0] a, b, input logic s1, s2, low,
                           input logic [TAG_W-1:0] tag);
        if (n == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_rs1_sign = s1;
            bus.req0_rs2_sign = s2; bus.req0_low = low; bus.req0_tag = tag;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_rs1_sign = s1;
            bus.req1_rs2_sign = s2; bus.req1_low = low; bus.req1_tag = tag;
        end
    endtask

    task automatic rand_req(input int n, input logic [TAG_W-1:0] tag);
        set_req(n, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), tag);
    endtask

    // Drive one cycle's controls (at posedge+1) and derive the expected outputs.
    task automatic apply(input logic v0, v1, frz, fl);
        bus.req0_valid = v0; bus.req1_valid = v1; freeze = frz; flush = fl;
        exp_g0 = 1'b0; exp_g1 = 1'b0;
        if (rst_l && !frz && !fl && (v0 || v1)) begin
            if (v0 && v1) begin
`ifdef RV_MUL_ARB_RR_EN
                if (last_win) exp_g0 = 1'b1; else exp_g1 = 1'b1;
`else
                exp_g0 = 1'b1;
`endif
            end else if (v0) exp_g0 = 1'b1;
            else             exp_g1 = 1'b1;
        end
        if (exp_g1) begin
            exp_ma = bus.req1_a; exp_mb = bus.req1_b; exp_s1 = bus.req1_rs1_sign;
            exp_s2 = bus.req1_rs2_sign; exp_low = bus.req1_low;
        end else begin
            exp_ma = bus.req0_a; exp_mb = bus.req0_b; exp_s1 = bus.req0_rs1_sign;
            exp_s2 = bus.req0_rs2_sign; exp_low = bus.req0_low;
        end
        exp_rv = 1'b0; exp_id = 1'b0; exp_tag = '0; exp_data = $urandom;
        if (inflight.size() != 0 && inflight[0].age == int'(LAT) && !frz && !fl) begin
            exp_rv = 1'b1; exp_id = inflight[0].id; exp_tag = inflight[0].tag;
            exp_data = inflight[0].prod;
        end
        bus.mul_result = exp_data;
        exp_busy = (inflight.size() != 0);
        #2;
    endtask

    // Clock edge: age the in-flight list according to flush/freeze/issue.
    task automatic advance();
        @(posedge clk);
        if (!rst_l) begin
            inflight.delete();
`ifdef RV_MUL_ARB_RR_EN
            last_win = 1'b0;
`endif
        end else if (flush) begin
            inflight.delete();
        end else if (!freeze) begin
            if (inflight.size() != 0 && inflight[0].age == int'(LAT)) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].age++;
            if (exp_g0 || exp_g1) begin
                inflight.push_back('{id: exp_g1, tag: (exp_g1 ? bus.req1_tag : bus.req0_tag),
                                     prod: mul_ref(exp_ma, exp_mb, exp_s1, exp_s2, exp_low), age: 1});
`ifdef RV_MUL_ARB_RR_EN
                last_win = exp_g1;
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rand_req(0, 5'd1); rand_req(1, 5'd2);
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
        total++; if (bus.mul_valid !== 1'b0) begin bad++; $display("FAIL reset_mul_valid got=%b exp=0", bus.mul_valid); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
        total++; if (bus.res_id !== 1'b0) begin bad++; $display("FAIL reset_res_id got=%b exp=0", bus.res_id); end
        total++; if (bus.res_tag !== '0) begin bad++; $display("FAIL reset_res_tag got=%0d exp=0", bus.res_tag); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        advance();
        rst_l = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_after got=%b exp=0", bus.busy); end
        advance();
    endtask

    task automatic test_single();
        set_req(0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b1, 5'd3); rand_req(1, 5'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b exp=0", bus.req1_ready); end
        total++; if (bus.mul_valid !== 1'b1) begin bad++; $display("FAIL single_mul_valid got=%b exp=1", bus.mul_valid); end
        total++; if ({bus.mul_a, bus.mul_b, bus.mul_low} !== {32'd7, 32'd6, 1'b1})
            begin bad++; $display("FAIL single_pkt got=%0d,%0d,%b exp=7,6,1", bus.mul_a, bus.mul_b, bus.mul_low); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy0 got=%b exp=0", bus.busy); end
        advance();
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (bus.res_valid !== (k == 3)) begin bad++; $display("FAIL single_res_valid k=%0d got=%b", k, bus.res_valid); end
            total++; if (bus.busy !== (k <= 3)) begin bad++; $display("FAIL single_busy k=%0d got=%b", k, bus.busy); end
            if (k == 3) begin
                total++; if ({bus.res_id, bus.res_tag, bus.res_data} !== {1'b0, 5'd3, 32'd42})
                    begin bad++; $display("FAIL single_result got=%b/%0d/%0d exp=0/3/42", bus.res_id, bus.res_tag, bus.res_data); end
            end
            advance();
        end
    endtask

    task automatic test_contend();
        logic [3:0] want1;
        int nres = 0;
`ifdef RV_MUL_ARB_RR_EN
        want1 = 4'b0101;
`else
        want1 = 4'b0000;
`endif
        for (int k = 0; k < 8; k++) begin
            rand_req(0, TAG_W'(k)); rand_req(1, TAG_W'(k + 8));
            apply(k < 4, k < 4, 1'b0, 1'b0);
            if (k < 4) begin
                total++; if (bus.req1_ready !== want1[k]) begin bad++; $display("FAIL contend_ready1 k=%0d got=%b exp=%b", k, bus.req1_ready, want1[k]); end
                total++; if (bus.req0_ready !== ~want1[k]) begin bad++; $display("FAIL contend_ready0 k=%0d got=%b exp=%b", k, bus.req0_ready, ~want1[k]); end
                total++; if (bus.mul_a !== exp_ma) begin bad++; $display("FAIL contend_mul_a k=%0d got=%h exp=%h", k, bus.mul_a, exp_ma); end
            end
            total++; if (bus.res_valid !== exp_rv) begin bad++; $display("FAIL contend_res_valid k=%0d got=%b exp=%b", k, bus.res_valid, exp_rv); end
            if (bus.res_valid === 1'b1) nres++;
            if (exp_rv) begin
                total++; if ({bus.res_id, bus.res_tag, bus.res_data} !== {exp_id, exp_tag, exp_data})
                    begin bad++; $display("FAIL contend_result k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, bus.res_id, bus.res_tag, bus.res_data, exp_id, exp_tag, exp_data); end
            end
            advance();
        end
        total++; if (nres != 4) begin bad++; $display("FAIL contend_count got=%0d exp=4", nres); end
    endtask

    task automatic test_freeze();
        logic frz;
        for (int k = 0; k <= 6; k++) begin
            frz = (k == 1) || (k == 2);
            rand_req(0, 5'd9); rand_req(1, 5'd10);
            apply((k == 0) || frz, frz, frz, 1'b0);
            total++; if (bus.mul_valid !== (k == 0)) begin bad++; $display("FAIL freeze_mul_valid k=%0d got=%b", k, bus.mul_valid); end
            total++; if ({bus.req0_ready, bus.req1_ready} !== {k == 0, 1'b0}) begin bad++; $display("FAIL freeze_ready k=%0d got=%b%b", k, bus.req0_ready, bus.req1_ready); end
            total++; if (bus.res_valid !== (k == 5)) begin bad++; $display("FAIL freeze_res_valid k=%0d got=%b", k, bus.res_valid); end
            total++; if (bus.busy !== (k >= 1 && k <= 5)) begin bad++; $display("FAIL freeze_busy k=%0d got=%b", k, bus.busy); end
            if (k == 5) begin
                total++; if ({bus.res_tag, bus.res_data} !== {5'd9, exp_data}) begin bad++; $display("FAIL freeze_result got=%0d/%h exp=9/%h", bus.res_tag, bus.res_data, exp_data); end
            end
            advance();
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k <= 7; k++) begin
            rand_req(0, TAG_W'(k)); rand_req(1, 5'd31);
            apply(k <= 3, 1'b0, 1'b0, k == 2);
            total++; if (bus.mul_valid !== (k <= 3 && k != 2)) begin bad++; $display("FAIL flush_mul_valid k=%0d got=%b", k, bus.mul_valid); end
            total++; if (bus.res_valid !== (k == 6)) begin bad++; $display("FAIL flush_res_valid k=%0d got=%b", k, bus.res_valid); end
            if (k == 3) begin
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
            end
            if (k == 6) begin
                total++; if (bus.res_tag !== 5'd3) begin bad++; $display("FAIL flush_new_tag got=%0d exp=3", bus.res_tag); end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 12; k++) begin
            rand_req(0, TAG_W'(k)); rand_req(1, TAG_W'(k + 16));
            apply(1'b1, 1'($urandom), 1'b0, 1'b0);
            total++; if (bus.mul_valid !== 1'b1) begin bad++; $display("FAIL b2b_mul_valid k=%0d got=%b", k, bus.mul_valid); end
            if (k >= 1) begin
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy k=%0d got=%b", k, bus.busy); end
            end
            if (k >= 3) begin
                total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL b2b_res_valid k=%0d got=%b", k, bus.res_valid); end
                total++; if ({bus.res_id, bus.res_tag, bus.res_data} !== {exp_id, exp_tag, exp_data})
                    begin bad++; $display("FAIL b2b_result k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, bus.res_id, bus.res_tag, bus.res_data, exp_id, exp_tag, exp_data); end
            end
            advance();
        end
        for (int d = 0; d < 4; d++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (bus.res_valid !== (d < 3)) begin bad++; $display("FAIL b2b_drain d=%0d got=%b", d, bus.res_valid); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_req(0, TAG_W'($urandom)); rand_req(1, TAG_W'($urandom));
            apply(1'($urandom), 1'($urandom), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
            total++; if ({bus.req0_ready, bus.req1_ready, bus.mul_valid} !== {exp_g0, exp_g1, exp_g0 | exp_g1})
                begin bad++; $display("FAIL rand_grant c=%0d got=%b%b%b exp=%b%b%b", c, bus.req0_ready, bus.req1_ready, bus.mul_valid, exp_g0, exp_g1, exp_g0 | exp_g1); end
            total++; if ({bus.mul_a, bus.mul_b, bus.mul_rs1_sign, bus.mul_rs2_sign, bus.mul_low} !== {exp_ma, exp_mb, exp_s1, exp_s2, exp_low})
                begin bad++; $display("FAIL rand_pkt c=%0d got=%h %h exp=%h %h", c, bus.mul_a, bus.mul_b, exp_ma, exp_mb); end
            total++; if (bus.res_valid !== exp_rv) begin bad++; $display("FAIL rand_res_valid c=%0d got=%b exp=%b", c, bus.res_valid, exp_rv); end
            total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
            total++; if (bus.res_data !== exp_data) begin bad++; $display("FAIL rand_res_data c=%0d got=%h exp=%h", c, bus.res_data, exp_data); end
            if (exp_rv) begin
                total++; if ({bus.res_id, bus.res_tag} !== {exp_id, exp_tag}) begin bad++; $display("FAIL rand_owner c=%0d got=%b/%0d exp=%b/%0d", c, bus.res_id, bus.res_tag, exp_id, exp_tag); end
            end
            advance();
        end
        for (int d = 0; d < 4; d++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 2; k++) begin
            rand_req(0, TAG_W'(k + 20));
            apply(1'b1, 1'b0, 1'b0, 1'b0);
            advance();
        end
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
        rst_l = 1'b0;
        #1;
        total++; if ({bus.req0_ready, bus.req1_ready, bus.mul_valid} !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b%b%b exp=000", bus.req0_ready, bus.req1_ready, bus.mul_valid); end
        total++; if ({bus.res_valid, bus.res_id, bus.res_tag} !== '0) begin bad++; $display("FAIL midrst_res got=%b/%b/%0d exp=0", bus.res_valid, bus.res_id, bus.res_tag); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        advance();
        rst_l = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if ({bus.res_valid, bus.busy} !== 2'b00) begin bad++; $display("FAIL midrst_after k=%0d got=%b%b exp=00", k, bus.res_valid, bus.busy); end
            advance();
        end
    endtask

    initial begin
        rst_l = 1'b0; freeze = 1'b0; flush = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.mul_result = '0;
        rand_req(0, '0); rand_req(1, '0);
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_contend();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
